mem_fill_arbiter: RTL
=====================

Name: mem_fill_arbiter

Overview:
- Single owner of the shared multi-cycle backing memory (memory4c).
- Arbitrates the I-cache miss, the D-cache miss and D-side write-through traffic onto that memory.
- For each miss, issues one pipelined block fill and drives the data-array and tag-array write strobes of the requesting cache.
- Sits between the two cache instances and memory4c inside the memory subsystem.

Parameters:
- MEM_LAT, 4, cycles from an issued read to its mem_data_valid.
- WORDS_PER_BLK, 8, 16-bit words per cache block; power of two.
- ADDR_W, 16, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_miss  in  1  I-cache miss_detected.
- i_addr  in  ADDR_W  I-cache access address.
- d_miss  in  1  D-cache miss_detected.
- d_addr  in  ADDR_W  D-cache access address.
- d_wen  in  1  D-side store request.
- mem_data_valid  in  1  memory read data valid.
- mem_addr  out  ADDR_W  memory address.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write (1) / read (0).
- i_stall  out  1  stall the fetch stage.
- d_stall  out  1  stall the memory stage.
- fill_addr  out  ADDR_W  cache address for the word being written into a data array.
- write_i_data_array  out  1  I data-array write strobe.
- write_i_tag_array  out  1  I tag-array write strobe.
- write_d_data_array  out  1  D data-array write strobe.
- write_d_tag_array  out  1  D tag-array write strobe.
- busy  out  1  a fill is in progress.

Behaviour:
- Reset, or rst low at any time including mid-fill:
  - state IDLE; issue_cnt=0, recv_cnt=0, latched base=0.
  - All strobes, mem_en, mem_wr, busy and both stalls are 0.
  - A fill in progress is abandoned with no tag write.
- States: IDLE, FILL_I, FILL_D.
- Block base address = addr with its log2(WORDS_PER_BLK)+1 LSBs cleared.
- IDLE priority, highest first:
  1. d_wen & ~d_miss: one-cycle write-through.
     - mem_en=1, mem_wr=1, mem_addr=d_addr.
     - Stay in IDLE. A pending i_miss waits one cycle.
  2. d_miss: latch the base of d_addr, go to FILL_D.
  3. i_miss: latch the base of i_addr, go to FILL_I.
  4. Otherwise mem_en=0.
- d_miss with d_wen (write miss) is write-allocate:
  - Fill first.
  - The store proceeds as a write hit once the miss clears.
- FILL_x issue phase, while issue_cnt < WORDS_PER_BLK:
  - Each cycle: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, then issue_cnt++.
  - One read per cycle; requests are never throttled.
- FILL_x receive phase:
  - Each cycle with mem_data_valid: pulse write_x_data_array with fill_addr = base + 2*recv_cnt, then recv_cnt++.
  - mem_data_valid is ignored in IDLE.
- On the valid that brings recv_cnt to WORDS_PER_BLK:
  - write_x_tag_array pulses in the same cycle as the last data write.
  - Next state is IDLE; counters clear.
- Latency: a fill occupies MEM_LAT+WORDS_PER_BLK cycles from entry to the FILL state to the tag write (12 cycles at defaults).
- Stalls (combinational):
  - i_stall = i_miss | (state==FILL_I).
  - d_stall = d_miss | (state==FILL_D) | (d_wen & state!=IDLE).
- A store arriving during any fill is held by d_stall and is not lost.
- busy = (state != IDLE).
- Simultaneous i_miss and d_miss in IDLE: D is served first; the I-fill starts the cycle after FILL_D returns to IDLE.
- The address inputs may change during a fill; only the latched base is used.

Optional Feature:
- Macro FILL_RR_EN.
- When defined:
  - A 1-bit last-grant register, reset to I, arbitrates simultaneous i_miss/d_miss round-robin.
  - The requester not granted last wins.
  - Write-through keeps top priority.
- When undefined: fixed D-over-I priority as above; no last-grant register.

Test Plan:
- Reset mid-fill: rst low after 3 valids of a D fill -> all strobes 0 immediately; after release no tag write, state IDLE, busy=0.
- Isolated I miss, i_addr=0x1236:
  - reads issued 0x1230..0x123E on 8 consecutive cycles;
  - 8 write_i_data_array pulses, fill_addr 0x1230..0x123E;
  - write_i_tag_array with the 8th;
  - i_stall is low the cycle after the tag write (i_miss clears).
- Simultaneous i_miss (0x0040) and d_miss (0x8008):
  - D fills 0x8000..0x800E first, then I fills 0x0040..0x004E;
  - with FILL_RR_EN, a second collision serves D then I again only if I was granted last.
- Write hit d_wen=1, d_addr=0x2002, idle -> one cycle mem_en=1, mem_wr=1, mem_addr=0x2002; d_stall=0.
- Store during I fill -> d_stall=1 until the fill ends; write issued the cycle the state is IDLE.
- Write miss d_wen=1, d_miss=1, d_addr=0x300A -> FILL_D of 0x3000..0x300E, then the write-through to 0x300A after d_miss drops.

Source files
------------

// File: rtl/mem_fill_arbiter.sv
// Backing-memory arbiter: write-through traffic and pipelined I/D block fills onto memory4c.
// Optional FILL_RR_EN: round-robin between colliding I and D misses (default: D over I).
module mem_fill_arbiter #(
  parameter int MEM_LAT       = 4,
  parameter int WORDS_PER_BLK = 8,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wen,
  input  logic              mem_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wr,
  output logic              i_stall,
  output logic              d_stall,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              write_i_data_array,
  output logic              write_i_tag_array,
  output logic              write_d_data_array,
  output logic              write_d_tag_array,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORDS_PER_BLK) + 1;
  localparam int OFF_W = $clog2(WORDS_PER_BLK) + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORDS_PER_BLK);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS_PER_BLK - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  if (WORDS_PER_BLK < 2 || (WORDS_PER_BLK & (WORDS_PER_BLK - 1)) != 0 || MEM_LAT < 1) begin : g_bad_cfg
    $error("mem_fill_arbiter: WORDS_PER_BLK must be a power of two >= 2 and MEM_LAT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic [ADDR_W-1:0] base;
  logic              write_thru;
  logic              grant_d;
  logic              grant_i;
  logic              last_word;

  assign write_thru = d_wen & ~d_miss;
  assign last_word  = (recv_cnt == CNT_LAST);

`ifdef FILL_RR_EN
  // last_d: 1 when the most recent fill grant went to the D side
  logic last_d;
  assign grant_d = d_miss & (~i_miss | ~last_d);
  assign grant_i = i_miss & (~d_miss | last_d);
`else
  assign grant_d = d_miss;
  assign grant_i = i_miss & ~d_miss;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
`ifdef FILL_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
          // a write-through occupies the memory this cycle; any miss waits
          if (!write_thru) begin
            if (grant_d) begin
              state <= FILL_D;
              base  <= d_addr & BASE_MASK;
`ifdef FILL_RR_EN
              last_d <= 1'b1;
`endif
            end else if (grant_i) begin
              state <= FILL_I;
              base  <= i_addr & BASE_MASK;
`ifdef FILL_RR_EN
              last_d <= 1'b0;
`endif
            end
          end
        end
        FILL_I, FILL_D: begin
          if (issue_cnt != CNT_FULL) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          if (mem_data_valid) begin
            if (last_word) begin
              state     <= IDLE;
              issue_cnt <= '0;
              recv_cnt  <= '0;
            end else begin
              recv_cnt <= recv_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue and receive phases overlap: reads keep going while early data returns.
  always_comb begin
    mem_en             = 1'b0;
    mem_wr             = 1'b0;
    mem_addr           = d_addr;
    fill_addr          = base + (ADDR_W'(recv_cnt) << 1);
    write_i_data_array = 1'b0;
    write_i_tag_array  = 1'b0;
    write_d_data_array = 1'b0;
    write_d_tag_array  = 1'b0;
    i_stall            = 1'b0;
    d_stall            = 1'b0;
    busy               = 1'b0;
    if (rst) begin
      busy    = (state != IDLE);
      i_stall = i_miss | (state == FILL_I);
      d_stall = d_miss | (state == FILL_D) | (d_wen & (state != IDLE));
      case (state)
        IDLE: begin
          if (write_thru) begin
            mem_en = 1'b1;
            mem_wr = 1'b1;
          end
        end
        FILL_I, FILL_D: begin
          if (issue_cnt != CNT_FULL) begin
            mem_en   = 1'b1;
            mem_addr = base + (ADDR_W'(issue_cnt) << 1);
          end
          if (mem_data_valid) begin
            if (state == FILL_I) begin
              write_i_data_array = 1'b1;
              write_i_tag_array  = last_word;
            end else begin
              write_d_data_array = 1'b1;
              write_d_tag_array  = last_word;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
